// File: rtl/cp0_if.sv
// Coprocessor-0 bus: controller strobes and EPC/IntReq return, plus the
// mtc0/mfc0 datapath ports.
interface cp0_if;
  logic        exl_set;
  logic        exl_clr;
  logic [31:0] epc_in;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        int_req;
  logic [31:0] epc_out;
  logic        exl;

  modport master (
    output exl_set, exl_clr, epc_in, we, waddr, wdata, raddr,
    input  rdata, int_req, epc_out, exl
  );

  modport slave (
    input  exl_set, exl_clr, epc_in, we, waddr, wdata, raddr,
    output rdata, int_req, epc_out, exl
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core: SR, Cause, EPC and PRId, with a
// synchroniser on the external interrupt lines feeding Cause.IP.
module cp0_unit #(
  parameter logic [31:0] PRID        = 32'h4D435055,
  parameter int unsigned HW_INT_W    = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HW_INT_W-1:0] hw_int,
  cp0_if.slave                bus
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [HW_INT_W-1:0] sync_q [SYNC_STAGES];

  logic [5:0]  im_q,  im_d;
  logic        ie_q,  ie_d;
  logic        exl_q, exl_d;
  logic [5:0]  ip_q,  ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] sr_w;
  logic [31:0] cause_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wr_sr  = bus.we && (bus.waddr == REG_SR);
  assign wr_epc = bus.we && (bus.waddr == REG_EPC);

  always_comb begin
    im_d  = im_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = '0;
    ip_d[HW_INT_W-1:0] = sync_q[SYNC_STAGES-1];

    // exception entry owns SR and EPC this cycle; otherwise mtc0 applies and
    // eret then forces EXL low on top of any SR write
    if (bus.exl_set) begin
      exl_d = 1'b1;
      exc_d = '0;
      epc_d = bus.epc_in & 32'hFFFF_FFFC;
    end else begin
      if (wr_sr) begin
        im_d  = bus.wdata[15:10];
        exl_d = bus.wdata[1];
        ie_d  = bus.wdata[0];
      end
      if (wr_epc) epc_d = bus.wdata;
      if (bus.exl_clr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= '0;
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      ie_q  <= ie_d;
      exl_q <= exl_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  assign sr_w    = {16'h0, im_q, 8'h0, exl_q, ie_q};
  assign cause_w = {16'h0, ip_q, 3'b000, exc_q, 2'b00};

  always_comb begin
    bus.rdata = '0;
    unique case (bus.raddr)
      REG_SR:    bus.rdata = sr_w;
      REG_CAUSE: bus.rdata = cause_w;
      REG_EPC:   bus.rdata = epc_q;
      REG_PRID:  bus.rdata = PRID;
      default:   bus.rdata = '0;
    endcase
  end

  assign bus.int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign bus.epc_out = epc_q;
  assign bus.exl     = exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expectations are queued as stimulus is
// driven and popped in order as each output is sampled.
module tb_cp0_unit;
  localparam int unsigned SYNC = 2;
  localparam logic [31:0] PRID = 32'h4D435055;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] hw_int = '0;

  cp0_if bus ();

  cp0_unit #(
    .PRID        (PRID),
    .HW_INT_W    (6),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .hw_int (hw_int),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, act, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.raddr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    cyc();
    bus.we    = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d;
    bus.exl_set = 1'b0;
    bus.exl_clr = 1'b0;
    bus.epc_in  = '0;
    bus.we      = 1'b0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.raddr   = 5'd15;

    repeat (2) cyc();
    reset = 1'b0;
    cyc();

    // T1: dirty some state, then reset mid-cycle
    mtc0(5'd12, 32'h0000_FC03);
    mtc0(5'd14, 32'hDEAD_BEEF);
    hw_int = 6'b111111;
    repeat (3) cyc();
    #2 reset = 1'b1;
    sb_push("t1_exl", 32'd0);
    sb_push("t1_intreq", 32'd0);
    sb_push("t1_epc", 32'd0);
    sb_push("t1_prid", PRID);
    sb_push("t1_sr", 32'd0);
    sb_push("t1_cause", 32'd0);
    #1;
    sb_pop_check(32'(bus.exl));
    sb_pop_check(32'(bus.int_req));
    sb_pop_check(bus.epc_out);
    rd(5'd15, d); sb_pop_check(d);
    rd(5'd12, d); sb_pop_check(d);
    rd(5'd13, d); sb_pop_check(d);
    hw_int = '0;
    cyc();
    reset = 1'b0;
    cyc();

    // T2: enable IM[0] and IE, then raise line 0 and watch the latency
    mtc0(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    for (int i = 1; i <= int'(SYNC) + 1; i++) begin
      sb_push($sformatf("t2_intreq_edge%0d", i), (i == int'(SYNC) + 1) ? 32'd1 : 32'd0);
      cyc();
      sb_pop_check(32'(bus.int_req));
    end
    sb_push("t2_cause", 32'h0000_0400);
    sb_push("t2_sr", 32'h0000_0401);
    rd(5'd13, d); sb_pop_check(d);
    rd(5'd12, d); sb_pop_check(d);

    // T3: interrupt taken
    bus.exl_set = 1'b1;
    bus.epc_in  = 32'h0000_3007;
    sb_push("t3_exl", 32'd1);
    sb_push("t3_epc", 32'h0000_3004);
    sb_push("t3_intreq", 32'd0);
    sb_push("t3_sr", 32'h0000_0403);
    cyc();
    bus.exl_set = 1'b0;
    sb_pop_check(32'(bus.exl));
    sb_pop_check(bus.epc_out);
    sb_pop_check(32'(bus.int_req));
    rd(5'd12, d); sb_pop_check(d);

    // T4: eret with the line still high
    bus.exl_clr = 1'b1;
    sb_push("t4_exl", 32'd0);
    sb_push("t4_intreq", 32'd1);
    cyc();
    bus.exl_clr = 1'b0;
    sb_pop_check(32'(bus.exl));
    sb_pop_check(32'(bus.int_req));

    // T5: exl_set beats concurrent mtc0 EPC
    bus.exl_set = 1'b1;
    bus.epc_in  = 32'h0000_ABCD;
    bus.we      = 1'b1;
    bus.waddr   = 5'd14;
    bus.wdata   = 32'h1234_5678;
    sb_push("t5_epc_vs_mtc0", 32'h0000_ABCC);
    sb_push("t5_exl_a", 32'd1);
    cyc();
    sb_pop_check(bus.epc_out);
    sb_pop_check(32'(bus.exl));

    // exl_set beats concurrent mtc0 SR and exl_clr
    bus.waddr   = 5'd12;
    bus.wdata   = 32'h0000_0000;
    bus.exl_clr = 1'b1;
    bus.epc_in  = 32'h5555_0002;
    sb_push("t5_exl_setclr", 32'd1);
    sb_push("t5_epc_setclr", 32'h5555_0000);
    sb_push("t5_sr_kept", 32'h0000_0403);
    cyc();
    bus.we      = 1'b0;
    bus.exl_set = 1'b0;
    sb_pop_check(32'(bus.exl));
    sb_pop_check(bus.epc_out);
    rd(5'd12, d); sb_pop_check(d);

    // eret with concurrent mtc0 SR: IM/IE taken, EXL still cleared
    bus.we    = 1'b1;
    bus.waddr = 5'd12;
    bus.wdata = 32'h0000_0C03;
    sb_push("t5_sr_clr_wr", 32'h0000_0C01);
    sb_push("t5_intreq_clr", 32'd1);
    cyc();
    bus.we      = 1'b0;
    bus.exl_clr = 1'b0;
    rd(5'd12, d); sb_pop_check(d);
    sb_pop_check(32'(bus.int_req));

    // exl_clr while EXL=0 is a no-op; plain mtc0 EPC keeps all bits
    bus.exl_clr = 1'b1;
    sb_push("t5_clr_idle", 32'd0);
    cyc();
    bus.exl_clr = 1'b0;
    sb_pop_check(32'(bus.exl));
    mtc0(5'd14, 32'h1234_5677);
    sb_push("t5_epc_mtc0", 32'h1234_5677);
    sb_pop_check(bus.epc_out);

    // T6: read-only registers and masking
    mtc0(5'd13, 32'hFFFF_FFFF);
    mtc0(5'd15, 32'hFFFF_FFFF);
    sb_push("t6_cause_ro", 32'h0000_0400);
    sb_push("t6_prid_ro", PRID);
    sb_push("t6_unmapped", 32'd0);
    rd(5'd13, d); sb_pop_check(d);
    rd(5'd15, d); sb_pop_check(d);
    rd(5'd5, d);  sb_pop_check(d);
    mtc0(5'd12, 32'h0000_0001);
    sb_push("t6_im0_intreq", 32'd0);
    sb_pop_check(32'(bus.int_req));
    mtc0(5'd12, 32'hFFFF_FFFF);
    sb_push("t6_sr_mask", 32'h0000_FC03);
    sb_push("t6_exl_blocks", 32'd0);
    rd(5'd12, d); sb_pop_check(d);
    sb_pop_check(32'(bus.int_req));

    // top line maps to IP bit 15
    mtc0(5'd12, 32'h0000_8001);
    hw_int = 6'b100000;
    repeat (SYNC + 1) cyc();
    sb_push("t6_ip15", 32'h0000_8000);
    sb_push("t6_intreq15", 32'd1);
    rd(5'd13, d); sb_pop_check(d);
    sb_pop_check(32'(bus.int_req));

    // reset drops pending lines in the chain
    hw_int = '0;
    cyc();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    cyc();
    sb_push("t6_chain_flush", 32'd0);
    rd(5'd13, d); sb_pop_check(d);

    sb_push("sb_drained", 32'd0);
    check_eq("sb_drained", 32'(sb_q.size()), sb_q.pop_front().exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
